// File: rtl/aq_axi_lite_master_if.sv
// AXI4-Lite master-side bus bundle used by aq_axi_lite_master.
// The master modport drives the request channels, and the slave modport mirrors it.
interface aq_axi_lite_master_if;
  logic [31:0] awaddr;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awcache, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arcache, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awcache, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arcache, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/aq_axi_lite_master.sv
// Single-beat local bus to AXI4-Lite master bridge.
// Only one transaction is outstanding at a time, and each transaction ends with a one-cycle LOCAL_ACK.
module aq_axi_lite_master #(
  parameter logic [3:0] AXI_CACHE = 4'b0011,
  parameter logic [2:0] AXI_PROT  = 3'b000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        LOCAL_CS,
  input  logic        LOCAL_RNW,
  input  logic [31:0] LOCAL_ADDR,
  input  logic [3:0]  LOCAL_BE,
  input  logic [31:0] LOCAL_WDATA,
  output logic        LOCAL_ACK,
  output logic        LOCAL_ERR,
  output logic [31:0] LOCAL_RDATA,
  aq_axi_lite_master_if.master m_axi
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;

    case (state_q)
      IDLE: begin
        if (LOCAL_CS) begin
          if (LOCAL_RNW) begin
            araddr_d  = LOCAL_ADDR;
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end else begin
            awaddr_d  = LOCAL_ADDR;
            wdata_d   = LOCAL_WDATA;
            wstrb_d   = LOCAL_BE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end
        end
      end
      WADDR: begin
        // AW and W retire independently; move on when neither is still pending after this edge.
        if (m_axi.awready) awvalid_d = 1'b0;
        if (m_axi.wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready))
          state_d = WRESP;
      end
      WRESP: begin
        if (m_axi.bvalid) begin
          err_d   = m_axi.bresp[1];
          rdata_d = '0;
          ack_d   = 1'b1;
          state_d = DONE;
        end
      end
      RADDR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          err_d   = m_axi.rresp[1];
          ack_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awcache = AXI_CACHE;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = (state_q == WRESP);
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arcache = AXI_CACHE;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state_q == RDATA);

  assign LOCAL_ACK   = ack_q;
  assign LOCAL_ERR   = err_q;
  assign LOCAL_RDATA = rdata_q;

endmodule

// File: tb/tb_aq_axi_lite_master.sv
// Randomized bench for aq_axi_lite_master: a delay-driven slave and a cycle-timing reference model
// derived from the per-channel wait counts.
module tb_aq_axi_lite_master;
  logic        clk = 1'b0;
  logic        arst;
  logic        cs, rnw_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        ack_o, err_o;
  logic [31:0] rdata_o;

  int checks = 0;
  int errors = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  int exp_writes = 0, exp_reads = 0;

  aq_axi_lite_master_if m_axi();

  aq_axi_lite_master dut (
    .ACLK(clk), .ARESET(arst),
    .LOCAL_CS(cs), .LOCAL_RNW(rnw_i), .LOCAL_ADDR(addr_i), .LOCAL_BE(be_i), .LOCAL_WDATA(wdata_i),
    .LOCAL_ACK(ack_o), .LOCAL_ERR(err_o), .LOCAL_RDATA(rdata_o),
    .m_axi(m_axi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!arst) begin
      if (m_axi.awvalid && m_axi.awready) aw_hs <= aw_hs + 1;
      if (m_axi.wvalid && m_axi.wready)   w_hs  <= w_hs + 1;
      if (m_axi.arvalid && m_axi.arready) ar_hs <= ar_hs + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic slave_idle();
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
    m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
    m_axi.rvalid = 1'b0; m_axi.rresp = 2'b00; m_axi.rdata = '0;
  endtask

  // Called at a negedge whose following posedge finds the DUT idle. The request is presented now.
  // Cycle n is the cycle after the n-th edge that counts from the sampling edge, edge 0.
  // Delay da/dw sets the READY of that channel in cycle 1+d. Delay db sets the B/R VALID db cycles after its READY.
  task automatic run_txn(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int da, input int dw, input int db,
                         input logic [1:0] resp, input logic [31:0] rd);
    int aw_end, w_end, p2_start, p2_end, ack_cyc;
    bit done2, hs2, got_ack;
    done2 = 0; hs2 = 0; got_ack = 0;
    cs = 1'b1; rnw_i = rnw; addr_i = addr; be_i = be; wdata_i = wd;
    aw_end   = 1 + da;
    w_end    = rnw ? 0 : 1 + dw;
    p2_start = rnw ? 2 + da : 2 + ((da > dw) ? da : dw);
    p2_end   = p2_start + db;
    ack_cyc  = p2_end + 1;
    if (rnw) exp_reads++; else exp_writes++;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40 && !got_ack; cyc++) begin
      @(negedge clk);
      if (hs2) done2 = 1;
      m_axi.awready = !rnw && (cyc == aw_end);
      m_axi.wready  = !rnw && (cyc == w_end);
      m_axi.arready = rnw && (cyc == aw_end);
      m_axi.bvalid  = !rnw && !done2 && (cyc >= p2_end);
      m_axi.bresp   = resp;
      m_axi.rvalid  = rnw && !done2 && (cyc >= p2_end);
      m_axi.rresp   = resp;
      m_axi.rdata   = rd;
      if (rnw) begin
        check_eq("arvalid", m_axi.arvalid, cyc <= aw_end);
        check_eq("awvalid_rd", m_axi.awvalid, 0);
        check_eq("rready", m_axi.rready, (cyc >= p2_start) && (cyc <= p2_end));
        if (cyc == 1) check_eq("araddr", m_axi.araddr, addr);
      end else begin
        check_eq("awvalid", m_axi.awvalid, cyc <= aw_end);
        check_eq("wvalid", m_axi.wvalid, cyc <= w_end);
        check_eq("arvalid_wr", m_axi.arvalid, 0);
        check_eq("bready", m_axi.bready, (cyc >= p2_start) && (cyc <= p2_end));
        if (cyc == 1) begin
          check_eq("awaddr", m_axi.awaddr, addr);
          check_eq("wdata", m_axi.wdata, wd);
          check_eq("wstrb", m_axi.wstrb, be);
        end
      end
      check_eq("ack", ack_o, cyc == ack_cyc);
      hs2 = (m_axi.bvalid && m_axi.bready) || (m_axi.rvalid && m_axi.rready);
      if (ack_o) begin
        got_ack = 1;
        check_eq("err", err_o, resp[1]);
        check_eq("rdata", rdata_o, rnw ? rd : 32'h0);
        $display("txn %s addr=0x%08h ack_cycle=%0d err=%0b rdata=0x%08h",
                 rnw ? "RD" : "WR", addr, cyc, err_o, rdata_o);
      end
    end
    if (!got_ack) check_eq("ack_timeout", 0, 1);
  endtask

  task automatic gap(input int n);
    cs = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic rnw;
    logic [1:0] resp;
    arst = 1'b1; cs = 1'b0; rnw_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
    slave_idle();
    repeat (3) @(negedge clk);
    check_eq("rst_awvalid", m_axi.awvalid, 0);
    check_eq("rst_wvalid", m_axi.wvalid, 0);
    check_eq("rst_arvalid", m_axi.arvalid, 0);
    check_eq("rst_bready", m_axi.bready, 0);
    check_eq("rst_rready", m_axi.rready, 0);
    check_eq("rst_ack", ack_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_eq("rst_awaddr", m_axi.awaddr, 0);
    check_eq("rst_araddr", m_axi.araddr, 0);
    check_eq("rst_wdata", m_axi.wdata, 0);
    check_eq("rst_wstrb", m_axi.wstrb, 0);
    check_eq("awcache", m_axi.awcache, 4'b0011);
    check_eq("arcache", m_axi.arcache, 4'b0011);
    check_eq("awprot", m_axi.awprot, 3'b000);
    check_eq("arprot", m_axi.arprot, 3'b000);
    arst = 1'b0;
    @(negedge clk);

    // Directed cases from the plan
    run_txn(1'b0, 32'h40, 4'hF, 32'hDEADBEEF, 0, 0, 0, 2'b00, 32'h0);
    gap(1);
    run_txn(1'b1, 32'h44, 4'h0, 32'h0, 2, 0, 3, 2'b00, 32'h12345678);
    gap(2);
    run_txn(1'b0, 32'h48, 4'h3, 32'hA5A5_0001, 0, 3, 1, 2'b00, 32'h0);
    gap(1);
    run_txn(1'b0, 32'h4C, 4'hC, 32'h1111_2222, 2, 0, 0, 2'b10, 32'h0);
    gap(1);
    run_txn(1'b1, 32'h50, 4'h0, 32'h0, 0, 0, 1, 2'b11, 32'hCAFE_F00D);
    // Stale CS stays high through the DONE edge, and then a new read arrives one cycle after ACK.
    @(negedge clk);
    run_txn(1'b1, 32'h54, 4'h0, 32'h0, 0, 0, 0, 2'b00, 32'h0BAD_CAFE);
    @(negedge clk);
    run_txn(1'b1, 32'h58, 4'h0, 32'h0, 0, 0, 0, 2'b01, 32'h7777_8888);

    // Reset while AWVALID is pending: everything drops, and no ACK is issued.
    gap(1);
    cs = 1'b1; rnw_i = 1'b0; addr_i = 32'h60; be_i = 4'hF; wdata_i = 32'h1234;
    slave_idle();
    @(negedge clk);
    check_eq("abort_awvalid_pre", m_axi.awvalid, 1);
    arst = 1'b1; cs = 1'b0;
    @(negedge clk);
    check_eq("abort_awvalid", m_axi.awvalid, 0);
    check_eq("abort_wvalid", m_axi.wvalid, 0);
    check_eq("abort_arvalid", m_axi.arvalid, 0);
    check_eq("abort_bready", m_axi.bready, 0);
    check_eq("abort_ack", ack_o, 0);
    arst = 1'b0;
    @(negedge clk);
    check_eq("abort_ack2", ack_o, 0);
    run_txn(1'b0, 32'h64, 4'h5, 32'h5555_AAAA, 0, 0, 0, 2'b00, 32'h0);

    for (int n = 0; n < 40; n++) begin
      int g;
      g = $urandom_range(0, 2);
      if (g == 0) @(negedge clk);
      else gap(g);
      rnw  = 1'($urandom_range(0, 1));
      resp = 2'($urandom_range(0, 3));
      run_txn(rnw, $urandom, 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp, $urandom);
    end

    gap(3);
    check_eq("aw_count", aw_hs, exp_writes);
    check_eq("w_count", w_hs, exp_writes);
    check_eq("ar_count", ar_hs, exp_reads);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
